// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 2R/1W register file with write-through bypass and busy scoreboard
//
// Purpose: register file between decode and the pipeline. Issue reserves a destination
// (busy bit set). Writeback (port C) writes data and clears busy. Read ports A and B are
// registered, report operand readiness, and drive a combinational stall request.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   read_addA/enable_A           port A read request
//   read_dataA/readyA            port A registered data and operand-ready flag
//   read_addB/enable_B           port B read request
//   read_dataB/readyB            port B registered data and operand-ready flag
//   write_addC/write_dataC/enable_C   writeback: write data, clear busy
//   reserve_add/enable_R         issue reservation: set busy
//   stall                        combinational operand-busy request from A/B
//   busy_count                   registered number of busy registers
module regfile_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_addA,
    input  logic              enable_A,
    output logic [DATA_W-1:0] read_dataA,
    output logic              readyA,
    input  logic [ADDR_W-1:0] read_addB,
    input  logic              enable_B,
    output logic [DATA_W-1:0] read_dataB,
    output logic              readyB,
    input  logic [ADDR_W-1:0] write_addC,
    input  logic [DATA_W-1:0] write_dataC,
    input  logic              enable_C,
    input  logic [ADDR_W-1:0] reserve_add,
    input  logic              enable_R,
    output logic              stall,
    output logic [ADDR_W:0]   busy_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_eff;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   busy_count_q;
    logic [ADDR_W:0]   busy_count_d;

    logic [DATA_W-1:0] read_dataA_q, read_dataA_d;
    logic [DATA_W-1:0] read_dataB_q, read_dataB_d;
    logic              readyA_q, readyA_d;
    logic              readyB_q, readyB_d;

    logic              wr_en;
    logic              rsv_en;
    logic              zero_a;
    logic              zero_b;

    // r0 is hardwired when ZERO_REG is set: its writes and reservations are dropped
    // here so neither the data array nor the scoreboard ever sees them.
    assign wr_en  = enable_C && !(ZERO_REG && (write_addC == '0));
    assign rsv_en = enable_R && !(ZERO_REG && (reserve_add == '0));
    assign zero_a = ZERO_REG && (read_addA == '0);
    assign zero_b = ZERO_REG && (read_addB == '0);

    // busy_eff: scoreboard as seen by this cycle's readers. The writeback clear is
    // visible immediately; a same-cycle reserve is not (it belongs to a younger op).
    // The reserve is applied after the clear so a collision leaves the bit set.
    always_comb begin
        busy_eff = busy_q;
        if (wr_en) begin
            busy_eff[write_addC] = 1'b0;
        end
        busy_d = busy_eff;
        if (rsv_en) begin
            busy_d[reserve_add] = 1'b1;
        end
    end

    always_comb begin
        busy_count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_count_d = busy_count_d + (ADDR_W+1)'(busy_d[i]);
        end
    end

    assign stall = (enable_A && busy_eff[read_addA]) || (enable_B && busy_eff[read_addB]);

    // Read-port next state; disabled ports hold their last result.
    always_comb begin
        read_dataA_d = read_dataA_q;
        readyA_d     = readyA_q;
        if (enable_A) begin
            if (zero_a) begin
                read_dataA_d = '0;
                readyA_d     = 1'b1;
            end else begin
                if (BYPASS && wr_en && (write_addC == read_addA)) begin
                    read_dataA_d = write_dataC;
                end else begin
                    read_dataA_d = regs_q[read_addA];
                end
                readyA_d = ~busy_eff[read_addA];
            end
        end
    end

    always_comb begin
        read_dataB_d = read_dataB_q;
        readyB_d     = readyB_q;
        if (enable_B) begin
            if (zero_b) begin
                read_dataB_d = '0;
                readyB_d     = 1'b1;
            end else begin
                if (BYPASS && wr_en && (write_addC == read_addB)) begin
                    read_dataB_d = write_dataC;
                end else begin
                    read_dataB_d = regs_q[read_addB];
                end
                readyB_d = ~busy_eff[read_addB];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[write_addC] <= write_dataC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= '0;
            busy_count_q <= '0;
            read_dataA_q <= '0;
            read_dataB_q <= '0;
            readyA_q     <= 1'b1;
            readyB_q     <= 1'b1;
        end else begin
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
            read_dataA_q <= read_dataA_d;
            read_dataB_q <= read_dataB_d;
            readyA_q     <= readyA_d;
            readyB_q     <= readyB_d;
        end
    end

    assign read_dataA = read_dataA_q;
    assign read_dataB = read_dataB_q;
    assign readyA     = readyA_q;
    assign readyB     = readyB_q;
    assign busy_count = busy_count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  read_addA, read_addB, write_addC, reserve_add;
    logic        enable_A, enable_B, enable_C, enable_R;
    logic [15:0] write_dataC;
    logic [15:0] read_dataA, read_dataB;
    logic        readyA, readyB, stall;
    logic [5:0]  busy_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .DATA_W(16), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .read_addA(read_addA), .enable_A(enable_A), .read_dataA(read_dataA), .readyA(readyA),
        .read_addB(read_addB), .enable_B(enable_B), .read_dataB(read_dataB), .readyB(readyB),
        .write_addC(write_addC), .write_dataC(write_dataC), .enable_C(enable_C),
        .reserve_add(reserve_add), .enable_R(enable_R),
        .stall(stall), .busy_count(busy_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        enable_A = 1'b0; enable_B = 1'b0; enable_C = 1'b0; enable_R = 1'b0;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        read_addA = '0; read_addB = '0; write_addC = '0; reserve_add = '0; write_dataC = '0;

        // 1 reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_dataA", read_dataA, 16'h0000);
        check("rst_readyA", readyA, 1'b1);
        check("rst_busy_count", busy_count, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;
        read_addA = 5'd5; enable_A = 1'b1;
        read_addB = 5'd31; enable_B = 1'b1;
        edge_sample();
        check("t1_dataA", read_dataA, 16'h0000);
        check("t1_dataB", read_dataB, 16'h0000);
        check("t1_readyA", readyA, 1'b1);
        check("t1_readyB", readyB, 1'b1);
        check("t1_busy_count", busy_count, 6'd0);

        // 2 write then read back
        @(negedge clk);
        idle();
        write_addC = 5'd3; write_dataC = 16'h0006; enable_C = 1'b1;
        edge_sample();
        @(negedge clk);
        idle();
        read_addA = 5'd3; enable_A = 1'b1;
        edge_sample();
        check("t2_dataA_r3", read_dataA, 16'h0006);

        // 3 bypass on A, plain read of r3 on B, same cycle
        @(negedge clk);
        idle();
        write_addC = 5'd7; write_dataC = 16'hBEEF; enable_C = 1'b1;
        read_addA = 5'd7; enable_A = 1'b1;
        read_addB = 5'd3; enable_B = 1'b1;
        edge_sample();
        check("t3_bypass_dataA", read_dataA, 16'hBEEF);
        check("t3_dataB_r3", read_dataB, 16'h0006);
        // disabled ports hold
        @(negedge clk);
        idle();
        read_addA = 5'd1; read_addB = 5'd1;
        edge_sample();
        check("t3_hold_dataA", read_dataA, 16'hBEEF);
        check("t3_hold_dataB", read_dataB, 16'h0006);

        // 4 scoreboard
        @(negedge clk);
        idle();
        reserve_add = 5'd5; enable_R = 1'b1;
        edge_sample();
        check("t4_busy_count_rsv", busy_count, 6'd1);
        @(negedge clk);
        idle();
        read_addA = 5'd5; enable_A = 1'b1;
        #1;
        check("t4_stall_busy", stall, 1'b1);
        edge_sample();
        check("t4_readyA_busy", readyA, 1'b0);
        check("t4_busy_count_hold", busy_count, 6'd1);
        @(negedge clk);
        write_addC = 5'd5; write_dataC = 16'h1234; enable_C = 1'b1;
        #1;
        check("t4_stall_cleared", stall, 1'b0);
        edge_sample();
        check("t4_dataA_wb", read_dataA, 16'h1234);
        check("t4_readyA_wb", readyA, 1'b1);
        check("t4_busy_count_wb", busy_count, 6'd0);

        // 5 collision on r9, then r0 write/reserve ignored
        @(negedge clk);
        idle();
        write_addC = 5'd9; write_dataC = 16'hAAAA; enable_C = 1'b1;
        reserve_add = 5'd9; enable_R = 1'b1;
        edge_sample();
        check("t5_collision_count", busy_count, 6'd1);
        @(negedge clk);
        idle();
        write_addC = 5'd0; write_dataC = 16'hFFFF; enable_C = 1'b1;
        reserve_add = 5'd0; enable_R = 1'b1;
        read_addA = 5'd0; enable_A = 1'b1;
        read_addB = 5'd9; enable_B = 1'b1;
        #1;
        check("t5_stall_r9", stall, 1'b1);
        edge_sample();
        check("t5_r0_dataA", read_dataA, 16'h0000);
        check("t5_r0_readyA", readyA, 1'b1);
        check("t5_r0_count", busy_count, 6'd1);
        check("t5_r9_dataB", read_dataB, 16'hAAAA);
        check("t5_r9_readyB", readyB, 1'b0);

        // 6 async reset mid-run with r2..r4 reserved and holding data
        @(negedge clk);
        idle();
        write_addC = 5'd2; write_dataC = 16'h0022; enable_C = 1'b1;
        edge_sample();
        @(negedge clk);
        idle();
        write_addC = 5'd4; write_dataC = 16'h0044; enable_C = 1'b1;
        reserve_add = 5'd2; enable_R = 1'b1;
        edge_sample();
        @(negedge clk);
        idle();
        reserve_add = 5'd3; enable_R = 1'b1;
        edge_sample();
        @(negedge clk);
        idle();
        reserve_add = 5'd4; enable_R = 1'b1;
        read_addA = 5'd2; enable_A = 1'b1;
        edge_sample();
        check("t6_count_4", busy_count, 6'd4);
        check("t6_dataA_r2", read_dataA, 16'h0022);
        check("t6_readyA_r2", readyA, 1'b0);
        @(negedge clk);
        idle();
        read_addA = 5'd3; enable_A = 1'b1;
        #1;
        check("t6_stall_pre", stall, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_async_dataA", read_dataA, 16'h0000);
        check("t6_async_readyA", readyA, 1'b1);
        check("t6_async_count", busy_count, 6'd0);
        check("t6_async_stall", stall, 1'b0);
        #1 rst_n = 1'b1;
        edge_sample();
        check("t6_post_r3_data", read_dataA, 16'h0000);
        check("t6_post_r3_ready", readyA, 1'b1);
        @(negedge clk);
        idle();
        read_addA = 5'd4; enable_A = 1'b1;
        edge_sample();
        check("t6_post_r4_data", read_dataA, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
